piso_serializer: RTL and testbench

Parallel-in/serial-out serializer built on the team's flip-flop primitives, sitting directly downstream of the register stage. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per `shift_en` tick. When the last bit completes it pulses `frame_done`. It feeds serial links and bit-banged peripherals that consume one bit per enable tick.

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_serializer_bit_counter.sv | 45 ++++
 rtl/piso_serializer.sv | 149 ++++++++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the parallel-in/serial-out serializer.
//   piso_state_e : FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width()  : bit-counter width for a given word width, clog2(WIDTH)
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

  // Counter width able to index every bit of a WIDTH-bit word.
  // Clamped to 1 so a degenerate width never yields a zero-width vector.
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: up-counter with enable, synchronous clear and terminal-count flag.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (count -> 0)
//   clr_i   : synchronous clear (count -> 0), has priority over en_i
//   en_i    : increment enable
//   tc_o    : high while count == LIMIT-1 (decoded from the register)
module bit_counter #(
  parameter int LIMIT = 8,
  parameter int CW    = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count decoded from the register only.
  assign tc_o = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over valid/ready and shifts it out
// one bit per shift_en tick, then pulses frame_done for one cycle.
//   clk_i          : clock, all state on rising edge
//   reset_i        : synchronous active-high reset
//   load_valid_i   : upstream word present on load_data_i
//   load_ready_o   : word accepted this cycle (high only in IDLE)
//   load_data_i    : parallel word, captured on handshake
//   shift_en_i     : bit-rate tick, advances one bit in SHIFT
//   ser_out_o      : current serial bit (0 outside SHIFT)
//   ser_valid_o    : ser_out_o carries a frame bit
//   busy_o         : high in SHIFT and DONE
//   frame_done_o   : one-cycle pulse after the final bit
// Every output is decoded from registered state only.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_en_i,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int CNT_W = int'(cnt_width(WIDTH));

  piso_state_e      state_q;
  piso_state_e      state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             accept_s;
  logic             advance_s;
  logic             cnt_tc_s;

  // Handshake can only happen in IDLE, where load_ready is high.
  assign accept_s  = (state_q == IDLE) && load_valid_i;
  // A tick on the last bit leaves the frame instead of shifting.
  assign advance_s = (state_q == SHIFT) && shift_en_i && !cnt_tc_s;

  bit_counter #(
    .LIMIT (WIDTH),
    .CW    (CNT_W)
  ) u_bit_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (accept_s),
    .en_i    (advance_s),
    .tc_o    (cnt_tc_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en_i && cnt_tc_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift-register next value: load, shift toward the output end, or hold.
  always_comb begin
    sreg_d = sreg_q;
    if (accept_s) begin
      sreg_d = load_data_i;
    end else if (advance_s) begin
      if (MSB_FIRST) begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      end
    end else begin
      sreg_d = sreg_q;
    end
  end

  // Shift register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    load_ready_o = 1'b0;
    ser_valid_o  = 1'b0;
    ser_out_o    = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready_o = 1'b1;
      end
      SHIFT: begin
        ser_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (MSB_FIRST) begin
          ser_out_o = sreg_q[WIDTH-1];
        end else begin
          ser_out_o = sreg_q[0];
        end
      end
      DONE: begin
        busy_o       = 1'b1;
        frame_done_o = 1'b1;
      end
      default: begin
        load_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: two instances (MSB-first and LSB-first) share stimulus;
// each is checked against bit orders computed here from the loaded word.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       shift_en;

  logic rdy_m, out_m, val_m, busy_m, done_m;
  logic rdy_l, out_l, val_l, busy_l, done_l;

  int tests = 0;
  int fails = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_valid_i (load_valid),
    .load_ready_o (rdy_m),
    .load_data_i  (load_data),
    .shift_en_i   (shift_en),
    .ser_out_o    (out_m),
    .ser_valid_o  (val_m),
    .busy_o       (busy_m),
    .frame_done_o (done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_valid_i (load_valid),
    .load_ready_o (rdy_l),
    .load_data_i  (load_data),
    .shift_en_i   (shift_en),
    .ser_out_o    (out_l),
    .ser_valid_o  (val_l),
    .busy_o       (busy_l),
    .frame_done_o (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " ready_m"}, rdy_m, 1'b1);
    chk({tag, " ready_l"}, rdy_l, 1'b1);
    chk({tag, " valid_m"}, val_m, 1'b0);
    chk({tag, " valid_l"}, val_l, 1'b0);
    chk({tag, " out_m"},   out_m, 1'b0);
    chk({tag, " out_l"},   out_l, 1'b0);
    chk({tag, " busy_m"},  busy_m, 1'b0);
    chk({tag, " busy_l"},  busy_l, 1'b0);
    chk({tag, " done_m"},  done_m, 1'b0);
    chk({tag, " done_l"},  done_l, 1'b0);
  endtask

  // Bit i of the frame: MSB-first sends d[7-i], LSB-first sends d[i].
  task automatic check_bit(input string tag, input logic [7:0] d, input int i);
    chk($sformatf("%s bit%0d out_m", tag, i), out_m, d[7-i]);
    chk($sformatf("%s bit%0d out_l", tag, i), out_l, d[i]);
    chk($sformatf("%s bit%0d valid_m", tag, i), val_m, 1'b1);
    chk($sformatf("%s bit%0d valid_l", tag, i), val_l, 1'b1);
    chk($sformatf("%s bit%0d busy", tag, i), busy_m, 1'b1);
    chk($sformatf("%s bit%0d ready", tag, i), rdy_m, 1'b0);
    chk($sformatf("%s bit%0d done", tag, i), done_m, 1'b0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, " done_m"},  done_m, 1'b1);
    chk({tag, " done_l"},  done_l, 1'b1);
    chk({tag, " valid_m"}, val_m, 1'b0);
    chk({tag, " out_m"},   out_m, 1'b0);
    chk({tag, " out_l"},   out_l, 1'b0);
    chk({tag, " ready_m"}, rdy_m, 1'b0);
    chk({tag, " busy_m"},  busy_m, 1'b1);
    chk({tag, " busy_l"},  busy_l, 1'b1);
  endtask

  // Frame with shift_en held high: 8 bits, DONE, then IDLE.
  task automatic run_fast_frame(input string tag, input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      check_bit(tag, d, i);
      tick();
    end
    check_done({tag, " done"});
    tick();
    check_idle({tag, " idle"});
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    shift_en   = 1'b0;

    // Reset and idle.
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");
    shift_en = 1'b1;
    tick();
    check_idle("idle_tick1");
    shift_en = 1'b0;
    tick();
    check_idle("idle_tick2");

    // MSB-first 0xA5 with shift_en held high.
    load_valid = 1'b1;
    load_data  = 8'hA5;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = 8'h00;
    run_fast_frame("a5", 8'hA5);

    // Sparse ticks, 0x0F: every bit held 3 cycles.
    shift_en   = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h0F;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        shift_en = (k == 2);
        check_bit($sformatf("sparse_c%0d", k), 8'h0F, i);
        tick();
      end
    end
    shift_en = 1'b0;
    check_done("sparse done");
    tick();
    check_idle("sparse idle");

    // Backpressure: 0x3C offered mid-frame of 0x55, data glitches first.
    load_valid = 1'b1;
    load_data  = 8'h55;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
      end
      if (i == 4) begin
        load_data = 8'h3C;
      end
      check_bit("bp55", 8'h55, i);
      tick();
    end
    check_done("bp55 done");
    tick();
    chk("bp idle ready", rdy_m, 1'b1);
    chk("bp idle valid", val_m, 1'b0);
    tick();
    load_valid = 1'b0;
    load_data  = 8'h00;
    run_fast_frame("bp3c", 8'h3C);

    // Reset after 3 bits of 0xFF, then 0x81.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bit("ff", 8'hFF, i);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midreset");
    tick();
    check_idle("midreset+1");
    load_valid = 1'b1;
    load_data  = 8'h81;
    tick();
    load_valid = 1'b0;
    run_fast_frame("x81", 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
